// File: rtl/camera_encode.sv
// camera_encode: camera link transmit word builder and 2-bit serialiser.
// Idle fill, 4-word frame sync, then FRAME_WORDS payload words; MSB first.
//
// Ports:
//   i_clk          symbol clock, one 2-bit symbol per cycle
//   i_reset        synchronous, active-high
//   i_frame_req    one-cycle pulse requesting one frame
//   i_din          pixel word
//   i_din_valid    i_din holds a valid word
//   o_din_ready    word taken this cycle when i_din_valid is also high
//   o_sym          serial symbol; o_sym[1] goes out first (DDIO high phase)
//   o_word_strobe  high on phase 0 of every word
//   o_frame_active high from first sync symbol to last payload symbol
//   o_frame_done   one-cycle pulse after the last payload symbol
//   o_underrun     sticky payload underrun; cleared by next accepted request
//
// Build option CAMERA_ENCODE_CLAMP_EN: clamp payload into 0x004..0x3FB.

module camera_encode #(
  parameter int         FRAME_WORDS = 463360,
  parameter logic [9:0] IDLE_WORD   = 10'h155,
  parameter int         CNT_W       = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_frame_req,
  input  logic [9:0] i_din,
  input  logic       i_din_valid,
  output logic       o_din_ready,
  output logic [1:0] o_sym,
  output logic       o_word_strobe,
  output logic       o_frame_active,
  output logic       o_frame_done,
  output logic       o_underrun
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PAY
  } state_t;

  localparam logic [9:0] SYNC0 = 10'h3FF;
  localparam logic [9:0] SYNC1 = 10'h000;
  localparam logic [9:0] SYNC2 = 10'h000;
  localparam logic [9:0] SYNC3 = 10'h200;

  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(FRAME_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE =
    CNT_W'(1);

  localparam logic [2:0] PH_LAST = 3'd4;

  state_t           r_state;
  state_t           w_state;
  logic [2:0]       r_phase;
  logic [2:0]       w_phase;
  logic [9:0]       r_word;
  logic [9:0]       w_word;
  logic [1:0]       r_sym;
  logic [1:0]       w_sym;
  logic             r_strobe;
  logic             w_strobe;
  logic             r_active;
  logic             w_active;
  logic             r_done;
  logic             w_done;
  logic             r_underrun;
  logic             w_underrun;
  logic             r_pending;
  logic             w_pending;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic [1:0]       r_sidx;
  logic [1:0]       w_sidx;
  // Set while the final payload word is on the wire.
  logic             r_last;
  logic             w_last;

  logic             w_tick;
  logic             w_accept;
  logic             w_pend;
  logic [9:0]       w_pix;
  logic [9:0]       w_sync;

  assign w_tick = (r_phase == PH_LAST);

  // Requests during a frame are dropped, never queued.
  assign w_accept = i_frame_req & ~r_active;
  assign w_pend   = r_pending | w_accept;

`ifdef CAMERA_ENCODE_CLAMP_EN
  // Keep pixel data off the 0x000/0x3FF sync codes.
  always_comb begin
    w_pix = i_din;
    if (i_din < 10'h004) begin
      w_pix = 10'h004;
    end else if (i_din > 10'h3FB) begin
      w_pix = 10'h3FB;
    end
  end
`else
  assign w_pix = i_din;
`endif

  always_comb begin
    w_sync = SYNC0;
    unique case (r_sidx)
      2'd0: w_sync = SYNC0;
      2'd1: w_sync = SYNC1;
      2'd2: w_sync = SYNC2;
      2'd3: w_sync = SYNC3;
      default: w_sync = SYNC0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_phase    <= 3'd0;
      r_word     <= IDLE_WORD;
      r_sym      <= 2'b00;
      r_strobe   <= 1'b0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
      r_pending  <= 1'b0;
      r_cnt      <= '0;
      r_sidx     <= 2'd0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_phase    <= w_phase;
      r_word     <= w_word;
      r_sym      <= w_sym;
      r_strobe   <= w_strobe;
      r_active   <= w_active;
      r_done     <= w_done;
      r_underrun <= w_underrun;
      r_pending  <= w_pending;
      r_cnt      <= w_cnt;
      r_sidx     <= w_sidx;
      r_last     <= w_last;
    end
  end

  // The FSM picks the word at phase 4; it is on the wire from phase 0.
  always_comb begin
    w_state    = r_state;
    w_phase    = w_tick ? 3'd0 : r_phase + 3'd1;
    w_word     = r_word;
    w_strobe   = w_tick;
    w_active   = r_active;
    w_done     = 1'b0;
    w_underrun = r_underrun;
    w_pending  = w_pend;
    w_cnt      = r_cnt;
    w_sidx     = r_sidx;
    w_last     = r_last;

    if (w_accept) begin
      w_underrun = 1'b0;
    end

    if (w_tick) begin
      if (r_last) begin
        w_active = 1'b0;
        w_done   = 1'b1;
        w_last   = 1'b0;
      end

      unique case (r_state)
        ST_IDLE: begin
          w_word = IDLE_WORD;
          if (w_pend) begin
            w_word     = SYNC0;
            w_state    = ST_SYNC;
            w_sidx     = 2'd1;
            w_pending  = 1'b0;
            w_underrun = 1'b0;
            w_active   = 1'b1;
          end
        end
        ST_SYNC: begin
          w_word = w_sync;
          w_sidx = r_sidx + 2'd1;
          if (r_sidx == 2'd3) begin
            w_state = ST_PAY;
          end
        end
        ST_PAY: begin
          // A missing word is replaced, not skipped.
          if (i_din_valid) begin
            w_word = w_pix;
          end else begin
            w_word     = IDLE_WORD;
            w_underrun = 1'b1;
          end
          w_cnt = r_cnt + CNT_ONE;
          if (r_cnt == LAST_CNT) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_last  = 1'b1;
          end
        end
        default: begin
          w_state = ST_IDLE;
        end
      endcase
    end

    w_sym = r_sym;
    unique case (r_phase)
      3'd0: w_sym = r_word[7:6];
      3'd1: w_sym = r_word[5:4];
      3'd2: w_sym = r_word[3:2];
      3'd3: w_sym = r_word[1:0];
      default: w_sym = w_word[9:8];
    endcase
  end

  assign o_din_ready    = w_tick & (r_state == ST_PAY);
  assign o_sym          = r_sym;
  assign o_word_strobe  = r_strobe;
  assign o_frame_active = r_active;
  assign o_frame_done   = r_done;
  assign o_underrun     = r_underrun;

endmodule

// File: tb/tb_camera_encode.sv
// tb_camera_encode: scoreboard bench for camera_encode, FRAME_WORDS=8.
// Words are rebuilt from o_sym and matched against an expected queue.

module tb_camera_encode;

  localparam int         FW   = 8;
  localparam logic [9:0] IDLE = 10'h155;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_req;
  logic [9:0] din;
  logic       din_valid;
  logic       o_din_ready;
  logic [1:0] o_sym;
  logic       o_word_strobe;
  logic       o_frame_active;
  logic       o_frame_done;
  logic       o_underrun;

  camera_encode #(
    .FRAME_WORDS(FW),
    .IDLE_WORD  (IDLE),
    .CNT_W      (20)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_frame_req   (frame_req),
    .i_din         (din),
    .i_din_valid   (din_valid),
    .o_din_ready   (o_din_ready),
    .o_sym         (o_sym),
    .o_word_strobe (o_word_strobe),
    .o_frame_active(o_frame_active),
    .o_frame_done  (o_frame_done),
    .o_underrun    (o_underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] got_q[$];
  logic       gact_q[$];
  logic [9:0] exp_q[$];
  logic [9:0] act_q[$];
  logic [9:0] pay[FW];

  int g_first;
  int g_done_at;
  int g_last_done;
  int g_done_n;
  int g_act_n;
  int g_rdy_n;

  int         m_ph = 0;
  logic [9:0] m_cur = '0;
  logic       m_act = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      m_ph = 0;
    end else begin
      if (o_word_strobe) begin
        m_ph  = 1;
        m_cur = {8'd0, o_sym};
        m_act = o_frame_active;
      end else if (m_ph != 0) begin
        m_cur = {m_cur[7:0], o_sym};
        m_ph++;
      end
      if (m_ph == 5) begin
        got_q.push_back(m_cur);
        gact_q.push_back(m_act);
        m_ph = 0;
      end
    end
  end

  function automatic logic [9:0] model_pix(input logic [9:0] d);
`ifdef CAMERA_ENCODE_CLAMP_EN
    if (d < 10'h004) return 10'h004;
    if (d > 10'h3FB) return 10'h3FB;
`endif
    return d;
  endfunction

  task automatic push_exp(input int skip);
    exp_q.push_back(10'h3FF);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h000);
    exp_q.push_back(10'h200);
    for (int k = 0; k < FW; k++) begin
      if (k == skip) exp_q.push_back(IDLE);
      else exp_q.push_back(model_pix(pay[k]));
    end
  endtask

  task automatic grab_act(input int base);
    act_q.delete();
    for (int i = base; i < got_q.size(); i++) begin
      if (gact_q[i]) act_q.push_back(got_q[i]);
    end
  endtask

  task automatic run(input int skip, input bit b2b);
    int k;
    int target;
    int tail;
    k = 0;
    target = b2b ? 2 : 1;
    tail = b2b ? 30 : 2;
    g_first = -1;
    g_done_at = -1;
    g_last_done = -1;
    g_done_n = 0;
    g_act_n = 0;
    g_rdy_n = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      frame_req = (cyc == 0);
      if (b2b && g_first >= 0 &&
          (cyc == g_first + 20 || cyc == g_first + 57))
        frame_req = 1'b1;
      if (b2b && o_frame_done && g_done_n == 0)
        frame_req = 1'b1;
      if (o_frame_active) begin
        g_act_n++;
        if (g_first < 0) g_first = cyc;
      end
      if (o_frame_done) begin
        g_done_n++;
        g_last_done = cyc;
        if (g_done_at < 0) g_done_at = cyc;
      end
      din_valid = 1'b1;
      if (o_din_ready) begin
        g_rdy_n++;
        din = pay[k % FW];
        din_valid = (k != skip);
        k++;
      end
      if (g_done_n >= target && cyc >= g_last_done + tail) break;
    end
    frame_req = 1'b0;
    din_valid = 1'b0;
  endtask

  task automatic test_reset;
    int base;
    int rdy;
    int act;
    reset = 1'b1;
    frame_req = 1'b0;
    din = '0;
    din_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({o_sym, o_din_ready, o_word_strobe, o_frame_active,
         o_frame_done, o_underrun} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs got sym=%b rdy=%b stb=%b act=%b done=%b und=%b want all 0",
               o_sym, o_din_ready, o_word_strobe, o_frame_active,
               o_frame_done, o_underrun);
    end
    reset = 1'b0;
    base = got_q.size();
    rdy = 0;
    act = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_din_ready) rdy++;
      if (o_frame_active) act++;
    end
    n_cmp++;
    if (rdy != 0) begin
      n_err++;
      $display("FAIL idle_ready got %0d want 0", rdy);
    end
    n_cmp++;
    if (act != 0) begin
      n_err++;
      $display("FAIL idle_active got %0d want 0", act);
    end
    n_cmp++;
    if (got_q.size() - base < 3) begin
      n_err++;
      $display("FAIL idle_words got %0d want >=3", got_q.size() - base);
    end
    for (int i = base; i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== IDLE || gact_q[i] !== 1'b0) begin
        n_err++;
        $display("FAIL idle_word[%0d] got %h/%b want %h/0",
                 i - base, got_q[i], gact_q[i], IDLE);
      end
    end
  endtask

  task automatic test_frame;
    int base;
    logic [9:0] e;
    logic [9:0] g;
    for (int i = 0; i < FW; i++) pay[i] = 10'(i + 1);
    base = got_q.size();
    push_exp(-1);
    run(-1, 1'b0);
    grab_act(base);
    n_cmp++;
    if (g_done_at < 0 || g_first < 0) begin
      n_err++;
      $display("FAIL frame_timeout first=%0d done=%0d want both >=0",
               g_first, g_done_at);
    end
    n_cmp++;
    if (g_first < 1 || g_first > 6) begin
      n_err++;
      $display("FAIL frame_latency got %0d want 1..6", g_first);
    end
    n_cmp++;
    if (g_done_at - g_first != 60) begin
      n_err++;
      $display("FAIL frame_done_pos got %0d want 60", g_done_at - g_first);
    end
    n_cmp++;
    if (g_done_n != 1) begin
      n_err++;
      $display("FAIL frame_done_count got %0d want 1", g_done_n);
    end
    n_cmp++;
    if (g_act_n != 60) begin
      n_err++;
      $display("FAIL frame_active_len got %0d want 60", g_act_n);
    end
    n_cmp++;
    if (g_rdy_n != FW) begin
      n_err++;
      $display("FAIL frame_ready_count got %0d want %0d", g_rdy_n, FW);
    end
    n_cmp++;
    if (o_underrun !== 1'b0) begin
      n_err++;
      $display("FAIL frame_underrun got %b want 0", o_underrun);
    end
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL frame_words got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL frame_word got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_underrun;
    int base;
    logic [9:0] e;
    logic [9:0] g;
    for (int i = 0; i < FW; i++) pay[i] = 10'(10'h100 + i);
    base = got_q.size();
    push_exp(2);
    run(2, 1'b0);
    grab_act(base);
    n_cmp++;
    if (o_underrun !== 1'b1) begin
      n_err++;
      $display("FAIL underrun_flag got %b want 1", o_underrun);
    end
    n_cmp++;
    if (g_done_n != 1 || g_act_n != 60) begin
      n_err++;
      $display("FAIL underrun_len got done=%0d act=%0d want 1/60",
               g_done_n, g_act_n);
    end
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL underrun_words got %0d want %0d",
               act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL underrun_word got %h want %h", g, e);
      end
    end
    base = got_q.size();
    push_exp(-1);
    run(-1, 1'b0);
    grab_act(base);
    n_cmp++;
    if (o_underrun !== 1'b0) begin
      n_err++;
      $display("FAIL underrun_clear got %b want 0", o_underrun);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL underrun_next_word got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int base;
    int runs;
    int gaps;
    logic prev;
    logic [9:0] e;
    logic [9:0] g;
    for (int i = 0; i < FW; i++) pay[i] = 10'(10'h040 + 3 * i);
    base = got_q.size();
    push_exp(-1);
    push_exp(-1);
    run(-1, 1'b1);
    grab_act(base);
    n_cmp++;
    if (g_done_n != 2) begin
      n_err++;
      $display("FAIL b2b_done_count got %0d want 2", g_done_n);
    end
    n_cmp++;
    if (g_act_n != 120) begin
      n_err++;
      $display("FAIL b2b_active_len got %0d want 120", g_act_n);
    end
    runs = 0;
    gaps = 0;
    prev = 1'b0;
    for (int i = base; i < got_q.size(); i++) begin
      if (gact_q[i] && !prev) runs++;
      if (!gact_q[i] && runs == 1) begin
        gaps++;
        n_cmp++;
        if (got_q[i] !== IDLE) begin
          n_err++;
          $display("FAIL b2b_gap_word got %h want %h", got_q[i], IDLE);
        end
      end
      prev = gact_q[i];
    end
    n_cmp++;
    if (runs != 2 || gaps < 1) begin
      n_err++;
      $display("FAIL b2b_frames got runs=%0d gap=%0d want 2/>=1", runs, gaps);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL b2b_word got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_reset_mid;
    int base;
    int first;
    int k;
    int act;
    logic [9:0] e;
    logic [9:0] g;
    for (int i = 0; i < FW; i++) pay[i] = 10'(10'h2A0 + i);
    first = -1;
    k = 0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      frame_req = (cyc == 0);
      din_valid = 1'b1;
      if (o_din_ready) begin
        din = pay[k % FW];
        k++;
      end
      if (o_frame_active && first < 0) first = cyc;
      if (first >= 0 && cyc == first + 36) begin
        reset = 1'b1;
        break;
      end
    end
    frame_req = 1'b0;
    n_cmp++;
    if (first < 0 || reset !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_start got first=%0d want >=0", first);
    end
    @(negedge clk);
    n_cmp++;
    if ({o_sym, o_din_ready, o_word_strobe, o_frame_active,
         o_frame_done, o_underrun} !== 7'b0) begin
      n_err++;
      $display("FAIL rstmid_outputs got sym=%b rdy=%b stb=%b act=%b done=%b und=%b want all 0",
               o_sym, o_din_ready, o_word_strobe, o_frame_active,
               o_frame_done, o_underrun);
    end
    reset = 1'b0;
    din_valid = 1'b0;
    act = 0;
    repeat (15) begin
      @(negedge clk);
      if (o_frame_active) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_err++;
      $display("FAIL rstmid_no_resume got %0d want 0", act);
    end
    base = got_q.size();
    push_exp(-1);
    run(-1, 1'b0);
    grab_act(base);
    n_cmp++;
    if (g_act_n != 60 || g_done_at - g_first != 60) begin
      n_err++;
      $display("FAIL rstmid_frame got act=%0d done_pos=%0d want 60/60",
               g_act_n, g_done_at - g_first);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL rstmid_word got %h want %h", g, e);
      end
    end
  endtask

  task automatic test_clamp;
    int base;
    logic [9:0] e;
    logic [9:0] g;
    pay[0] = 10'h000;
    pay[1] = 10'h3FF;
    pay[2] = 10'h004;
    pay[3] = 10'h3FB;
    pay[4] = 10'h003;
    pay[5] = 10'h3FC;
    pay[6] = 10'h200;
    pay[7] = 10'h155;
    base = got_q.size();
    push_exp(-1);
    run(-1, 1'b0);
    grab_act(base);
    n_cmp++;
    if (act_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL clamp_words got %0d want %0d", act_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (act_q.size() > 0) ? act_q.pop_front() : 10'bx;
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL clamp_word got %h want %h", g, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    frame_req = 1'b0;
    din = '0;
    din_valid = 1'b0;
    test_reset();
    test_frame();
    test_underrun();
    test_back_to_back();
    test_reset_mid();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
